// File: rtl/simple_prog_loader.sv
// Byte-stream program loader: assembles big-endian 16-bit words into instruction
// memory and holds the CPU in reset until the final word has been written.
module simple_prog_loader (
  input  logic        clk,
  input  logic        reset,
  input  logic        s_valid,
  input  logic [7:0]  s_data,
  input  logic        s_last,
  output logic        s_ready,
  output logic        imem_wren,
  output logic [7:0]  imem_waddr,
  output logic [15:0] imem_wdata,
  output logic        cpu_resetn,
  output logic        load_done,
  output logic        load_err,
  output logic [8:0]  instr_count
);

  typedef enum logic [2:0] {
    S_HI  = 3'd0,
    S_LO  = 3'd1,
    S_WR  = 3'd2,
    S_RUN = 3'd3,
    S_ERR = 3'd4
  } state_t;

  localparam logic [8:0] COUNT_MAX = 9'd256;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] hi_byte;
  logic [7:0] lo_byte;
  logic       last_flag;
  logic       accept;

  assign accept = s_valid & s_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_HI;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      S_HI: begin
        if (accept) begin
          state_nxt = s_last ? S_ERR : S_LO;
        end
      end
      S_LO: begin
        if (accept) begin
          state_nxt = S_WR;
        end
      end
      S_WR: begin
        if (last_flag) begin
          state_nxt = S_RUN;
        end else if (instr_count[7:0] == 8'hFF) begin
          state_nxt = S_ERR;
        end else begin
          state_nxt = S_HI;
        end
      end
      S_RUN:   state_nxt = S_RUN;
      S_ERR:   state_nxt = S_ERR;
      default: state_nxt = S_ERR;
    endcase
  end

  // Moore outputs: decoded from registered state and word registers only.
  always_comb begin
    s_ready    = 1'b0;
    imem_wren  = 1'b0;
    imem_waddr = 8'd0;
    imem_wdata = 16'd0;
    cpu_resetn = 1'b0;
    load_done  = 1'b0;
    load_err   = 1'b0;
    case (state)
      S_HI, S_LO: s_ready = 1'b1;
      S_WR: begin
        imem_wren  = 1'b1;
        imem_waddr = instr_count[7:0];
        imem_wdata = {hi_byte, lo_byte};
      end
      S_RUN: begin
        cpu_resetn = 1'b1;
        load_done  = 1'b1;
      end
      S_ERR:   load_err = 1'b1;
      default: load_err = 1'b1;
    endcase
  end

  // NOTE: the word-assembly registers are deliberately left out of reset; they
  // are always written by a handshake before WR can read them.
  always_ff @(posedge clk) begin
    if (state == S_HI && accept) begin
      hi_byte <= s_data;
    end
    if (state == S_LO && accept) begin
      lo_byte   <= s_data;
      last_flag <= s_last;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_count <= 9'd0;
    end else if (state == S_WR && instr_count != COUNT_MAX) begin
      instr_count <= instr_count + 9'd1;
    end
  end

endmodule

// File: tb/tb_simple_prog_loader.sv
// Self-checking bench for simple_prog_loader: table-driven load scenarios plus
// hand-written corner sequences, with a write scoreboard fed by a byte model.
module tb_simple_prog_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = 8'd0;
  logic        s_last = 1'b0;
  logic        s_ready;
  logic        imem_wren;
  logic [7:0]  imem_waddr;
  logic [15:0] imem_wdata;
  logic        cpu_resetn;
  logic        load_done;
  logic        load_err;
  logic [8:0]  instr_count;

  simple_prog_loader dut (
    .clk        (clk),
    .reset      (reset),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_last     (s_last),
    .s_ready    (s_ready),
    .imem_wren  (imem_wren),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .cpu_resetn (cpu_resetn),
    .load_done  (load_done),
    .load_err   (load_err),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          nbytes;
    logic [31:0] bytes;
    logic        last_final;
    logic        exp_done;
    logic        exp_err;
    int          exp_count;
  } vec_t;

  int          tests_run    = 0;
  int          tests_failed = 0;
  logic [23:0] sb[$];
  int          m_words;
  logic        m_phase;
  logic [7:0]  m_hi;
  logic [7:0]  prog[512];

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Reference model of the byte stream: pushes {addr, word} on each completed pair.
  task automatic model_byte(input logic [7:0] data, input logic last);
    if (!m_phase) begin
      if (!last) begin
        m_hi    = data;
        m_phase = 1'b1;
      end
    end else begin
      sb.push_back({m_words[7:0], m_hi, data});
      m_words++;
      m_phase = 1'b0;
    end
  endtask

  // Write monitor, sampled on the falling edge.
  always @(negedge clk) begin
    logic [23:0] exp_w;
    if (imem_wren) begin
      if (sb.size() == 0) begin
        check("unexpected_write", {8'd0, imem_waddr, imem_wdata}, 32'd0);
      end else begin
        exp_w = sb.pop_front();
        check("waddr", {24'd0, imem_waddr}, {24'd0, exp_w[23:16]});
        check("wdata", {16'd0, imem_wdata}, {16'd0, exp_w[15:0]});
      end
      check("s_ready_in_wr", {31'd0, s_ready}, 32'd0);
    end else begin
      check("idle_bus_zero", {8'd0, imem_waddr, imem_wdata}, 32'd0);
    end
  end

  task automatic do_reset(input logic with_byte);
    reset   = 1'b1;
    s_valid = with_byte;
    s_data  = 8'h55;
    s_last  = 1'b1;
    @(posedge clk);
    #1;
    reset   = 1'b0;
    s_valid = 1'b0;
    s_last  = 1'b0;
    m_words = 0;
    m_phase = 1'b0;
    sb.delete();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_s_ready"},    {31'd0, s_ready},    32'd1);
    check({tag, "_wren"},       {31'd0, imem_wren},  32'd0);
    check({tag, "_cpu_resetn"}, {31'd0, cpu_resetn}, 32'd0);
    check({tag, "_done"},       {31'd0, load_done},  32'd0);
    check({tag, "_err"},        {31'd0, load_err},   32'd0);
    check({tag, "_count"},      {23'd0, instr_count}, 32'd0);
  endtask

  task automatic send_byte(input logic [7:0] data, input logic last, input int max_gap);
    int   gap;
    int   tries;
    logic acc;
    gap     = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
    tries   = 0;
    s_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    s_valid = 1'b1;
    s_data  = data;
    s_last  = last;
    do begin
      acc = s_ready;
      @(posedge clk);
      #1;
      tries++;
    end while (!acc && tries < 50);
    if (!acc) check("accept_timeout", 32'd0, 32'd1);
    else model_byte(data, last);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_end(input int budget);
    int n;
    n = 0;
    while (!(load_done || load_err) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!(load_done || load_err)) check("end_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_end(input string tag, input logic done, input logic err,
                           input int count);
    check({tag, "_done"},       {31'd0, load_done},  {31'd0, done});
    check({tag, "_err"},        {31'd0, load_err},   {31'd0, err});
    check({tag, "_cpu_resetn"}, {31'd0, cpu_resetn}, {31'd0, done});
    check({tag, "_s_ready"},    {31'd0, s_ready},    32'd0);
    check({tag, "_count"},      {23'd0, instr_count}, count);
    check({tag, "_sb_drained"}, sb.size(),           32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "global timeout");
  end

  initial begin
    vec_t vecs[4];
    vecs[0] = '{4, 32'h12345678, 1'b1, 1'b1, 1'b0, 2};
    vecs[1] = '{1, 32'hAB000000, 1'b1, 1'b0, 1'b1, 0};
    vecs[2] = '{2, 32'hCAFE0000, 1'b1, 1'b1, 1'b0, 1};
    vecs[3] = '{3, 32'h11223300, 1'b1, 1'b0, 1'b1, 1};

    for (int i = 0; i < 4; i++) begin
      do_reset(1'b0);
      check_reset_state($sformatf("v%0d_rst", i));
      for (int j = 0; j < vecs[i].nbytes; j++) begin
        logic [31:0] b;
        b = vecs[i].bytes;
        send_byte(b[31-8*j -: 8], vecs[i].last_final && (j == vecs[i].nbytes - 1), 0);
      end
      wait_end(10);
      check_end($sformatf("v%0d", i), vecs[i].exp_done, vecs[i].exp_err, vecs[i].exp_count);
    end

    // Same 8-word program gap-free and with random valid gaps.
    for (int k = 0; k < 16; k++) prog[k] = 8'($urandom);
    for (int pass = 0; pass < 2; pass++) begin
      do_reset(1'b0);
      for (int k = 0; k < 16; k++) send_byte(prog[k], k == 15, pass * 5);
      wait_end(10);
      check_end($sformatf("gap%0d", pass), 1'b1, 1'b0, 8);
    end

    // Full 256-word image, with and without the final s_last.
    for (int k = 0; k < 512; k++) prog[k] = 8'(k) ^ 8'h5A;
    for (int pass = 0; pass < 2; pass++) begin
      do_reset(1'b0);
      for (int k = 0; k < 512; k++) send_byte(prog[k], (pass == 0) && (k == 511), 0);
      wait_end(10);
      check_end($sformatf("full%0d", pass), pass == 0, pass == 1, 256);
    end

    // Reset mid-load discards the partial word and restarts at address 0.
    do_reset(1'b0);
    send_byte(8'h12, 1'b0, 0);
    send_byte(8'h34, 1'b0, 0);
    send_byte(8'h56, 1'b0, 0);
    @(posedge clk);
    #1;
    check("midload_sb_drained", sb.size(), 32'd0);
    do_reset(1'b0);
    check_reset_state("midload_rst");
    send_byte(8'h9A, 1'b0, 0);
    send_byte(8'hBC, 1'b1, 0);
    wait_end(10);
    check_end("midload", 1'b1, 1'b0, 1);

    // Reset wins over a coincident handshake; then hold s_valid in RUN.
    do_reset(1'b1);
    check_reset_state("coinc_rst");
    send_byte(8'hDE, 1'b0, 0);
    send_byte(8'hAD, 1'b1, 0);
    wait_end(10);
    check_end("coinc", 1'b1, 1'b0, 1);
    s_valid = 1'b1;
    s_data  = 8'h77;
    s_last  = 1'b1;
    repeat (8) begin
      @(posedge clk);
      #1;
      check("run_hold_s_ready", {31'd0, s_ready},   32'd0);
      check("run_hold_wren",    {31'd0, imem_wren}, 32'd0);
      check("run_hold_done",    {30'd0, load_done, cpu_resetn}, 32'd3);
      check("run_hold_count",   {23'd0, instr_count}, 32'd1);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
